mc_decoder: RTL and testbench

MC_DECODER -- requirements
Module: mc_decoder

---
 rtl/mc_decoder.sv | 115 +++++++++++
 tb/tb_mc_decoder.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mc_decoder.sv
// mc_decoder: multicycle main FSM plus ALU/PC decoders for the datapath control stage.
// Define DECODER_CMP_EN to retire CMP (Funct[4:1]=1010, S=1) without the ALUWB write.
module mc_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [1:0] FlagW,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic       NextPC,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } state_t;
    state_t state, state_next;
    logic       alu_op, branch, cmp;
    logic [1:0] alu_ctl;
`ifdef DECODER_CMP_EN
    assign cmp = Funct[4:0] == 5'b10101;
`else
    assign cmp = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE:   state_next = (Op == 2'b01) ? MEMADR :
                                   (Op == 2'b10) ? BRANCH :
                                   (Op == 2'b11) ? UNKNOWN :
                                   Funct[5]      ? EXECUTEI : EXECUTER;
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER,
            EXECUTEI: state_next = cmp ? FETCH : ALUWB;
            UNKNOWN:  state_next = UNKNOWN;
            default:  state_next = FETCH;
        endcase
    end
    always_comb begin
        RegW      = 1'b0;
        MemW      = 1'b0;
        NextPC    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMRD:    AdrSrc  = 1'b1;
            MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: alu_op = 1'b1;
            EXECUTEI: begin
                alu_op  = 1'b1;
                ALUSrcB = 2'b01;
            end
            ALUWB:    RegW = 1'b1;
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end
    // Unsupported commands fall back to ADD; CMP is forced to SUB when enabled.
    assign alu_ctl    = cmp                      ? 2'b01 :
                        (Funct[4:1] == 4'b0100) ? 2'b00 :
                        (Funct[4:1] == 4'b0010) ? 2'b01 :
                        (Funct[4:1] == 4'b0000) ? 2'b10 :
                        (Funct[4:1] == 4'b1100) ? 2'b11 : 2'b00;
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign FlagW      = alu_op ? {Funct[0], Funct[0] & ~alu_ctl[1]} : 2'b00;
    assign PCS        = (RegW & (Rd == 4'hF)) | branch;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
endmodule

// File: tb/tb_mc_decoder.sv
// tb_mc_decoder: random instruction stream checked cycle by cycle against a phase-list model.
// Honours DECODER_CMP_EN the same way the design does.
module tb_mc_decoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic [3:0] Rd = 4'd0;
    logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc;
    logic [19:0] obs;
    int tests = 0;
    int fails = 0;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MWR = 5,
                   P_ER = 6, P_EI = 7, P_AWB = 8, P_BR = 9, P_U = 10;
    string names [11] = '{"fetch", "decode", "memadr", "memrd", "memwb", "memwr",
                          "executer", "executei", "aluwb", "branch", "unknown"};

    mc_decoder dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc)
    );

    always #5 clk = ~clk;

    assign obs = {FlagW, PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic bit is_cmp(input logic [5:0] f);
`ifdef DECODER_CMP_EN
        return f[4:0] == 5'b10101;
`else
        return 1'b0;
`endif
    endfunction

    // Output vector for one cycle spent in phase p with the given instruction fields.
    function automatic logic [19:0] exp_out(input int p, input logic [1:0] op,
                                            input logic [5:0] f, input logic [3:0] rd);
        logic [1:0] flagw = 2'b00, res = 2'b00, sa = 2'b00, sb = 2'b00, aluc = 2'b00;
        logic regw = 0, memw = 0, npc = 0, irw = 0, adr = 0, br = 0, alu = 0;
        case (p)
            P_F:   begin irw = 1; npc = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
            P_D:   begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
            P_MA:  sb = 2'b01;
            P_MR:  adr = 1;
            P_MWB: begin regw = 1; res = 2'b01; end
            P_MWR: begin adr = 1; memw = 1; end
            P_ER:  alu = 1;
            P_EI:  begin alu = 1; sb = 2'b01; end
            P_AWB: regw = 1;
            P_BR:  begin sa = 2'b10; sb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        if (alu) begin
            case (f[4:1])
                4'b0010: aluc = 2'b01;
                4'b0000: aluc = 2'b10;
                4'b1100: aluc = 2'b11;
                default: aluc = 2'b00;
            endcase
            if (is_cmp(f)) aluc = 2'b01;
            flagw = {f[0], f[0] && (aluc == 2'b00 || aluc == 2'b01)};
        end
        return {flagw, (regw && rd == 4'hF) || br, regw, memw, npc, irw, adr, res,
                sa, sb, aluc, op, op == 2'b01, op == 2'b10};
    endfunction

    // Runs one instruction from FETCH; reset is raised during phase index abort_at (-1 = never).
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input int abort_at);
        int seq[$];
        bit stop;
        seq = '{P_F, P_D};
        case (op)
            2'b01: if (f[0]) seq = {seq, P_MA, P_MR, P_MWB}; else seq = {seq, P_MA, P_MWR};
            2'b00: begin
                seq.push_back(f[5] ? P_EI : P_ER);
                if (!is_cmp(f)) seq.push_back(P_AWB);
            end
            2'b10: seq.push_back(P_BR);
            default: seq = {seq, P_U, P_U, P_U};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            if (seq[i] == P_F) {Op, Funct, Rd} = 12'($urandom);
            else {Op, Funct, Rd} = {op, f, rd};
            stop = (i == abort_at) || (op == 2'b11 && i == seq.size() - 1);
            reset = stop;
            @(negedge clk);
            check(names[seq[i]], obs, exp_out(seq[i], Op, Funct, Rd));
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (stop) break;
        end
    endtask

    logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

    initial begin
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(2'b01, 6'b011001, 4'h3, -1);
        run_instr(2'b01, 6'b011000, 4'h5, -1);
        run_instr(2'b00, 6'b001001, 4'hF, -1);
        run_instr(2'b10, 6'b000000, 4'h0, -1);
        run_instr(2'b11, 6'b000000, 4'hF, -1);
        run_instr(2'b00, 6'b010101, 4'h2, -1);
        run_instr(2'b00, 6'b110101, 4'hF, -1);
        run_instr(2'b00, 6'b111000, 4'hF, -1);
        run_instr(2'b01, 6'b000001, 4'hF, 3);
        run_instr(2'b01, 6'b000000, 4'h1, 2);
        run_instr(2'b00, 6'b000100, 4'hF, 2);
        for (int n = 0; n < 300; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            op = 2'($urandom);
            f  = 6'($urandom);
            rd = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if (op == 2'b00 && $urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 4)];
            run_instr(op, f, rd, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : -1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
